eh2_tlu_trigger_ctl: RTL and testbench

Per-thread debug-trigger CSR owner and hit handler in the TLU. Holds `mtsel`/`tdata1`/`tdata2` state for 4 mcontrol triggers per thread and drives `trigger_pkt_any` to the decode/LSU matchers. At commit, it consumes their raw per-trigger match vectors, applies pair chaining, sets `hit` bits, and raises a registered breakpoint-exception or debug-halt request.

---
 rtl/eh2_pkg.sv | 68 ++++++
 rtl/eh2_trigger_chain.sv | 24 ++
 rtl/eh2_tlu_trigger_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_eh2_tlu_trigger_ctl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared trigger types and constants for the TLU debug-trigger logic.
package eh2_pkg;

    // Live trigger configuration handed to the decode/LSU matchers.
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } eh2_trigger_pkt_t;

    // Trigger CSR addresses.
    localparam logic [11:0] MTSEL  = 12'h7A0;
    localparam logic [11:0] TDATA1 = 12'h7A1;
    localparam logic [11:0] TDATA2 = 12'h7A2;

    // mcontrol (tdata1) bit positions.
    localparam int MC_TYPE_LSB = 28;
    localparam int MC_DMODE    = 27;
    localparam int MC_HIT      = 20;
    localparam int MC_SELECT   = 19;
    localparam int MC_ACTION   = 12;
    localparam int MC_CHAIN    = 11;
    localparam int MC_MATCH    = 7;
    localparam int MC_M        = 6;
    localparam int MC_EXECUTE  = 2;
    localparam int MC_STORE    = 1;
    localparam int MC_LOAD     = 0;

    // The type field is hardwired to "address/data match".
    localparam logic [3:0] MC_TYPE = 4'h2;

    // Stored (writable) mcontrol state of one trigger.
    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mcontrol_t;

    // Rebuild the architectural tdata1 word from the stored fields.
    function automatic logic [31:0] mcontrol_to_csr(input mcontrol_t c);
        logic [31:0] v;
        v                     = '0;
        v[MC_TYPE_LSB +: 4]   = MC_TYPE;
        v[MC_DMODE]           = c.dmode;
        v[MC_HIT]             = c.hit;
        v[MC_SELECT]          = c.select;
        v[MC_ACTION]          = c.action;
        v[MC_CHAIN]           = c.chain;
        v[MC_MATCH]           = c.match;
        v[MC_M]               = c.m;
        v[MC_EXECUTE]         = c.execute;
        v[MC_STORE]           = c.store;
        v[MC_LOAD]            = c.load;
        return v;
    endfunction

endpackage

// File: rtl/eh2_trigger_chain.sv
// Pair chaining of raw trigger matches: (0,1) and (2,3).
module eh2_trigger_chain (
    input  logic [3:0] i_raw,
    input  logic       i_chain0,
    input  logic       i_chain2,
    output logic [3:0] o_fire
);

    logic [1:0] w_chain;

    assign w_chain = {i_chain2, i_chain0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_pair
            logic w_both;
            assign w_both = i_raw[2*gi] & i_raw[2*gi+1];
            // A chained pair fires together only when both halves match.
            assign o_fire[2*gi]   = w_chain[gi] ? w_both : i_raw[2*gi];
            assign o_fire[2*gi+1] = w_chain[gi] ? w_both : i_raw[2*gi+1];
        end
    endgenerate

endmodule

// File: rtl/eh2_tlu_trigger_ctl.sv
// Per-thread debug-trigger CSRs, commit-time hit handling and fire request.
module eh2_tlu_trigger_ctl
    import eh2_pkg::*;
#(
    parameter int NUM_THREADS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_l,
    input  logic                                   dec_csr_wen,
    input  logic                                   dec_csr_wtid,
    input  logic [11:0]                            dec_csr_waddr,
    input  logic [31:0]                            dec_csr_wrdata,
    input  logic                                   dec_csr_rtid,
    input  logic [11:0]                            dec_csr_raddr,
    output logic [31:0]                            trig_csr_rddata,
    input  logic [NUM_THREADS-1:0]                 dec_dbg_mode,
    input  logic                                   i0_commit_valid,
    input  logic                                   i1_commit_valid,
    input  logic                                   i0_commit_tid,
    input  logic                                   i1_commit_tid,
    input  logic [3:0]                             i0_trigger_raw,
    input  logic [3:0]                             i1_trigger_raw,
    output eh2_trigger_pkt_t [NUM_THREADS-1:0][3:0] trigger_pkt_any,
    output logic                                   trig_fire_valid,
    output logic                                   trig_fire_tid,
    output logic                                   trig_fire_halt,
    output logic                                   trig_fire_slot
);

    // Storage always exists for two threads; thread 1 is inert when absent.
    localparam logic [1:0] THREAD_EN = (NUM_THREADS > 1) ? 2'b11 : 2'b01;

    logic [1:0]             w_dbg;
    logic [1:0][1:0]        w_mtsel;
    mcontrol_t [1:0][3:0]   w_mc;
    logic [1:0][3:0][31:0]  w_tdata2;
    logic [1:0][3:0]        w_action;
    logic [1:0][3:0]        w_fired;
    logic [1:0]             w_wr_thread;

    logic [3:0] w_i0_raw_q, w_i1_raw_q;
    logic [3:0] w_i0_fire, w_i1_fire;
    logic       w_i0_any, w_i1_any, w_i1_eval;
    logic       w_i0_halt, w_i1_halt;

    logic r_fire_valid, r_fire_tid, r_fire_halt, r_fire_slot;

    generate
        if (NUM_THREADS > 1) begin : gen_dbg_mt
            assign w_dbg = dec_dbg_mode[1:0];
        end else begin : gen_dbg_st
            assign w_dbg = {1'b0, dec_dbg_mode[0]};
        end
    endgenerate

    // Per-thread CSR state: mtsel plus four mcontrol/tdata2 triggers.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_thr
            logic [1:0] r_mtsel;

            assign w_wr_thread[gi] = dec_csr_wen && (dec_csr_wtid == 1'(gi)) && THREAD_EN[gi];
            assign w_mtsel[gi]     = r_mtsel;

            // mtsel holds only the trigger index; writes are never locked.
            always_ff @(posedge clk) begin
                if (!rst_l) begin
                    r_mtsel <= 2'b00;
                end else if (w_wr_thread[gi] && (dec_csr_waddr == MTSEL)) begin
                    r_mtsel <= dec_csr_wrdata[1:0];
                end
            end

            for (gj = 0; gj < 4; gj++) begin : gen_trg
                localparam bit CHAIN_OK = (gj % 2) == 0;

                mcontrol_t   r_mc;
                logic [31:0] r_tdata2;
                mcontrol_t   w_wr_mc;
                logic        w_target, w_locked, w_wr_t1, w_wr_t2;

                assign w_target = w_wr_thread[gi] && (r_mtsel == 2'(gj));
                // A debug-mode-owned trigger is read-only to machine mode.
                assign w_locked = r_mc.dmode && !w_dbg[gi];
                assign w_wr_t1  = w_target && !w_locked && (dec_csr_waddr == TDATA1);
                assign w_wr_t2  = w_target && !w_locked && (dec_csr_waddr == TDATA2);

                // Decode a tdata1 write; a same-cycle fire still sets hit.
                always_comb begin
                    w_wr_mc         = '0;
                    w_wr_mc.dmode   = dec_csr_wrdata[MC_DMODE] & w_dbg[gi];
                    w_wr_mc.hit     = dec_csr_wrdata[MC_HIT] | w_fired[gi][gj];
                    w_wr_mc.select  = dec_csr_wrdata[MC_SELECT];
                    w_wr_mc.action  = dec_csr_wrdata[MC_ACTION] & w_dbg[gi];
                    w_wr_mc.chain   = dec_csr_wrdata[MC_CHAIN] & CHAIN_OK;
                    w_wr_mc.match   = dec_csr_wrdata[MC_MATCH];
                    w_wr_mc.m       = dec_csr_wrdata[MC_M];
                    w_wr_mc.execute = dec_csr_wrdata[MC_EXECUTE];
                    w_wr_mc.store   = dec_csr_wrdata[MC_STORE];
                    w_wr_mc.load    = dec_csr_wrdata[MC_LOAD];
                end

                // Trigger state update: CSR write wins, otherwise sticky hit.
                always_ff @(posedge clk) begin
                    if (!rst_l) begin
                        r_mc     <= '0;
                        r_tdata2 <= '0;
                    end else begin
                        if (w_wr_t1) begin
                            r_mc <= w_wr_mc;
                        end else if (w_fired[gi][gj]) begin
                            r_mc.hit <= 1'b1;
                        end
                        if (w_wr_t2) begin
                            r_tdata2 <= dec_csr_wrdata;
                        end
                    end
                end

                assign w_mc[gi][gj]     = r_mc;
                assign w_tdata2[gi][gj] = r_tdata2;
                assign w_action[gi][gj] = r_mc.action;
            end
        end

        for (gi = 0; gi < NUM_THREADS; gi++) begin : gen_pkt_thr
            for (gj = 0; gj < 4; gj++) begin : gen_pkt_trg
                assign trigger_pkt_any[gi][gj] = {w_mc[gi][gj].select, w_mc[gi][gj].match,
                                                  w_mc[gi][gj].store,  w_mc[gi][gj].load,
                                                  w_mc[gi][gj].execute, w_mc[gi][gj].m,
                                                  w_tdata2[gi][gj]};
            end
        end
    endgenerate

    // Raw matches are dropped for a thread that is already in debug mode.
    assign w_i0_raw_q = i0_trigger_raw & {4{i0_commit_valid & ~w_dbg[i0_commit_tid]
                                            & THREAD_EN[i0_commit_tid]}};
    assign w_i1_raw_q = i1_trigger_raw & {4{i1_commit_valid & ~w_dbg[i1_commit_tid]
                                            & THREAD_EN[i1_commit_tid]}};

    eh2_trigger_chain u_chain_i0 (
        .i_raw    (w_i0_raw_q),
        .i_chain0 (w_mc[i0_commit_tid][0].chain),
        .i_chain2 (w_mc[i0_commit_tid][2].chain),
        .o_fire   (w_i0_fire)
    );

    eh2_trigger_chain u_chain_i1 (
        .i_raw    (w_i1_raw_q),
        .i_chain0 (w_mc[i1_commit_tid][0].chain),
        .i_chain2 (w_mc[i1_commit_tid][2].chain),
        .o_fire   (w_i1_fire)
    );

    // i1 is younger: it is squashed by an i0 fire of the same thread only.
    assign w_i0_any  = |w_i0_fire;
    assign w_i1_eval = !w_i0_any || (i1_commit_tid != i0_commit_tid);
    assign w_i1_any  = w_i1_eval && (|w_i1_fire);
    assign w_i0_halt = |(w_i0_fire & w_action[i0_commit_tid]);
    assign w_i1_halt = |(w_i1_fire & w_action[i1_commit_tid]);

    // Collect the hit bits to set, per thread and trigger.
    always_comb begin
        w_fired = '0;
        if (w_i0_any) begin
            w_fired[i0_commit_tid] = w_i0_fire;
        end
        if (w_i1_eval) begin
            w_fired[i1_commit_tid] = w_fired[i1_commit_tid] | w_i1_fire;
        end
    end

    // Registered one-cycle fire request; i0 takes precedence over i1.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_fire_valid <= 1'b0;
            r_fire_tid   <= 1'b0;
            r_fire_halt  <= 1'b0;
            r_fire_slot  <= 1'b0;
        end else begin
            r_fire_valid <= w_i0_any | w_i1_any;
            r_fire_tid   <= w_i0_any ? i0_commit_tid : (w_i1_any ? i1_commit_tid : 1'b0);
            r_fire_halt  <= w_i0_any ? w_i0_halt : (w_i1_any ? w_i1_halt : 1'b0);
            r_fire_slot  <= !w_i0_any && w_i1_any;
        end
    end

    assign trig_fire_valid = r_fire_valid;
    assign trig_fire_tid   = r_fire_tid;
    assign trig_fire_halt  = r_fire_halt;
    assign trig_fire_slot  = r_fire_slot;

    // Combinational CSR read against the current register contents.
    always_comb begin
        trig_csr_rddata = '0;
        case (dec_csr_raddr)
            MTSEL:   trig_csr_rddata = {30'b0, w_mtsel[dec_csr_rtid]};
            TDATA1:  trig_csr_rddata = mcontrol_to_csr(w_mc[dec_csr_rtid][w_mtsel[dec_csr_rtid]]);
            TDATA2:  trig_csr_rddata = w_tdata2[dec_csr_rtid][w_mtsel[dec_csr_rtid]];
            default: trig_csr_rddata = '0;
        endcase
    end

endmodule

// File: tb/tb_eh2_tlu_trigger_ctl.sv
// Scoreboard bench for eh2_tlu_trigger_ctl: directed plan plus random traffic.
module tb_eh2_tlu_trigger_ctl;
    import eh2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        dec_csr_wen, dec_csr_wtid, dec_csr_rtid;
    logic [11:0] dec_csr_waddr, dec_csr_raddr;
    logic [31:0] dec_csr_wrdata, trig_csr_rddata;
    logic [1:0]  dec_dbg_mode;
    logic        i0_commit_valid, i1_commit_valid, i0_commit_tid, i1_commit_tid;
    logic [3:0]  i0_trigger_raw, i1_trigger_raw;
    eh2_trigger_pkt_t [1:0][3:0] trigger_pkt_any;
    logic        trig_fire_valid, trig_fire_tid, trig_fire_halt, trig_fire_slot;

    eh2_tlu_trigger_ctl #(.NUM_THREADS(2)) dut (
        .clk(clk), .rst_l(rst_l),
        .dec_csr_wen(dec_csr_wen), .dec_csr_wtid(dec_csr_wtid),
        .dec_csr_waddr(dec_csr_waddr), .dec_csr_wrdata(dec_csr_wrdata),
        .dec_csr_rtid(dec_csr_rtid), .dec_csr_raddr(dec_csr_raddr),
        .trig_csr_rddata(trig_csr_rddata), .dec_dbg_mode(dec_dbg_mode),
        .i0_commit_valid(i0_commit_valid), .i1_commit_valid(i1_commit_valid),
        .i0_commit_tid(i0_commit_tid), .i1_commit_tid(i1_commit_tid),
        .i0_trigger_raw(i0_trigger_raw), .i1_trigger_raw(i1_trigger_raw),
        .trigger_pkt_any(trigger_pkt_any),
        .trig_fire_valid(trig_fire_valid), .trig_fire_tid(trig_fire_tid),
        .trig_fire_halt(trig_fire_halt), .trig_fire_slot(trig_fire_slot)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int edge_no; bit tid; bit halt; bit slot; } exp_fire_t;
    exp_fire_t sb[$];

    // Reference model: architectural tdata1 words, tdata2 words, mtsel.
    localparam logic [31:0] T1_WMASK = 32'h0818_18C7;
    logic [31:0] m_t1 [2][4];
    logic [31:0] m_t2 [2][4];
    logic [1:0]  m_sel [2];

    task automatic model_reset();
        for (int th = 0; th < 2; th++) begin
            m_sel[th] = 2'd0;
            for (int t = 0; t < 4; t++) begin
                m_t1[th][t] = 32'h2000_0000;
                m_t2[th][t] = 32'h0;
            end
        end
    endtask

    function automatic logic [3:0] m_fires(bit v, bit tid, logic [3:0] raw, logic [1:0] dbg);
        logic [3:0] q, f;
        q = (v && !dbg[tid]) ? raw : 4'b0;
        f = q;
        for (int p = 0; p < 4; p += 2) begin
            if (m_t1[tid][p][11]) begin
                f[p]   = q[p] && q[p+1];
                f[p+1] = f[p];
            end
        end
        return f;
    endfunction

    function automatic bit m_halt(bit tid, logic [3:0] f);
        bit h = 0;
        for (int t = 0; t < 4; t++) if (f[t] && m_t1[tid][t][12]) h = 1;
        return h;
    endfunction

    function automatic logic [31:0] m_read(bit tid, logic [11:0] a);
        if (a == 12'h7A0) return {30'b0, m_sel[tid]};
        if (a == 12'h7A1) return m_t1[tid][m_sel[tid]];
        if (a == 12'h7A2) return m_t2[tid][m_sel[tid]];
        return 32'h0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    // One clock: predict from current inputs, advance, update model, queue fire.
    task automatic step();
        logic [3:0] f0, f1;
        logic [3:0] fired [2];
        bit any0, any1, ev1, fv, ft, fh, fs, rst_n, we, wt;
        logic [11:0] wa;
        logic [31:0] wd, v;
        logic [1:0]  dbg, sel;
        dbg   = dec_dbg_mode;
        rst_n = rst_l;
        we = dec_csr_wen; wt = dec_csr_wtid; wa = dec_csr_waddr; wd = dec_csr_wrdata;
        f0 = m_fires(i0_commit_valid, i0_commit_tid, i0_trigger_raw, dbg);
        f1 = m_fires(i1_commit_valid, i1_commit_tid, i1_trigger_raw, dbg);
        any0 = |f0;
        ev1  = !any0 || (i1_commit_tid != i0_commit_tid);
        any1 = ev1 && (|f1);
        fired[0] = 4'b0; fired[1] = 4'b0;
        if (any0) fired[i0_commit_tid] = fired[i0_commit_tid] | f0;
        if (ev1)  fired[i1_commit_tid] = fired[i1_commit_tid] | f1;
        fv = any0 || any1;
        if (any0) begin ft = i0_commit_tid; fs = 0; fh = m_halt(i0_commit_tid, f0); end
        else      begin ft = i1_commit_tid; fs = 1; fh = m_halt(i1_commit_tid, f1); end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            fv = 0;
        end else begin
            for (int th = 0; th < 2; th++)
                for (int t = 0; t < 4; t++)
                    if (fired[th][t]) m_t1[th][t][20] = 1'b1;
            if (we) begin
                sel = m_sel[wt];
                if (wa == 12'h7A0) m_sel[wt] = wd[1:0];
                else if (!(m_t1[wt][sel][27] && !dbg[wt])) begin
                    if (wa == 12'h7A1) begin
                        v = wd & T1_WMASK;
                        if (!dbg[wt]) begin v[27] = 1'b0; v[12] = 1'b0; end
                        if (sel[0]) v[11] = 1'b0;
                        v[31:28] = 4'h2;
                        v[20] = wd[20] | fired[wt][sel];
                        m_t1[wt][sel] = v;
                    end else if (wa == 12'h7A2) begin
                        m_t2[wt][sel] = wd;
                    end
                end
            end
        end
        #1;
        if (fv) sb.push_back('{edge_no: edge_cnt, tid: ft, halt: fh, slot: fs});
    endtask

    task automatic idle_inputs();
        dec_csr_wen = 0; i0_commit_valid = 0; i1_commit_valid = 0;
        i0_trigger_raw = 4'b0; i1_trigger_raw = 4'b0;
        i0_commit_tid = 0; i1_commit_tid = 0;
    endtask

    task automatic csr_wr(bit t, logic [11:0] a, logic [31:0] d);
        dec_csr_wen = 1; dec_csr_wtid = t; dec_csr_waddr = a; dec_csr_wrdata = d;
        step();
        dec_csr_wen = 0;
    endtask

    task automatic commit(bit v0, bit t0, logic [3:0] r0, bit v1, bit t1, logic [3:0] r1);
        i0_commit_valid = v0; i0_commit_tid = t0; i0_trigger_raw = r0;
        i1_commit_valid = v1; i1_commit_tid = t1; i1_trigger_raw = r1;
        step();
        idle_inputs();
    endtask

    task automatic rd_chk(string nm, bit t, logic [11:0] a, logic [31:0] exp);
        dec_csr_rtid = t; dec_csr_raddr = a;
        #1;
        chk(nm, trig_csr_rddata, exp);
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a fire.
    initial begin
        exp_fire_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
                e = sb.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL fire_missing: got valid=0 at edge %0d, expected fire tid=%0d", e.edge_no, e.tid);
            end
            if (trig_fire_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL fire_unexpected: got fire at edge %0d, expected none", edge_cnt);
                end else begin
                    e = sb.pop_front();
                    if (e.edge_no != edge_cnt || e.tid != trig_fire_tid ||
                        e.halt != trig_fire_halt || e.slot != trig_fire_slot) begin
                        n_bad++;
                        $display("FAIL fire_fields: got edge=%0d tid=%0d halt=%0d slot=%0d, expected edge=%0d tid=%0d halt=%0d slot=%0d",
                                 edge_cnt, trig_fire_tid, trig_fire_halt, trig_fire_slot,
                                 e.edge_no, e.tid, e.halt, e.slot);
                    end else begin
                        $display("fire edge=%0d tid=%0d halt=%0d slot=%0d ok", edge_cnt,
                                 trig_fire_tid, trig_fire_halt, trig_fire_slot);
                    end
                end
            end
        end
    end

    eh2_trigger_pkt_t [1:0][3:0] exp_pkt;

    task automatic pkt_chk();
        for (int th = 0; th < 2; th++)
            for (int t = 0; t < 4; t++) begin
                exp_pkt[th][t].select  = m_t1[th][t][19];
                exp_pkt[th][t].match   = m_t1[th][t][7];
                exp_pkt[th][t].store   = m_t1[th][t][1];
                exp_pkt[th][t].load    = m_t1[th][t][0];
                exp_pkt[th][t].execute = m_t1[th][t][2];
                exp_pkt[th][t].m       = m_t1[th][t][6];
                exp_pkt[th][t].tdata2  = m_t2[th][t];
            end
        n_cmp++;
        if (trigger_pkt_any !== exp_pkt) begin
            n_bad++;
            $display("FAIL trigger_pkt: got %h, expected %h", trigger_pkt_any, exp_pkt);
        end
    endtask

    initial begin
        logic [11:0] addrs [5];
        addrs[0] = 12'h7A0; addrs[1] = 12'h7A1; addrs[2] = 12'h7A2;
        addrs[3] = 12'h7A3; addrs[4] = 12'h300;
        model_reset();
        idle_inputs();
        dec_csr_wtid = 0; dec_csr_waddr = 0; dec_csr_wrdata = 0;
        dec_csr_rtid = 0; dec_csr_raddr = 0; dec_dbg_mode = 2'b00;
        rst_l = 0;
        step(); step();
        rst_l = 1;

        // Reset state.
        chk("reset_fire_valid", {31'b0, trig_fire_valid}, 32'h0);
        pkt_chk();
        rd_chk("reset_mtsel", 0, MTSEL, 32'h0);
        rd_chk("reset_tdata1", 0, TDATA1, 32'h2000_0000);
        rd_chk("reset_tdata2", 1, TDATA2, 32'h0);

        // Configure trigger 1 of thread 0.
        csr_wr(0, MTSEL, 32'h1);
        csr_wr(0, TDATA2, 32'h8000_0100);
        csr_wr(0, TDATA1, 32'h2000_0044);
        chk("pkt01_execute", {31'b0, trigger_pkt_any[0][1].execute}, 32'h1);
        chk("pkt01_m", {31'b0, trigger_pkt_any[0][1].m}, 32'h1);
        chk("pkt01_tdata2", trigger_pkt_any[0][1].tdata2, 32'h8000_0100);
        rd_chk("cfg_tdata1", 0, TDATA1, 32'h2000_0044);

        // Single fire on trigger 1.
        commit(1, 0, 4'b0010, 0, 0, 4'b0);
        chk("fire1_valid", {29'b0, trig_fire_valid, trig_fire_halt, trig_fire_slot}, 32'h4);
        rd_chk("fire1_hit", 0, TDATA1, 32'h2010_0044);

        // Chain on trigger 0.
        csr_wr(0, TDATA1, 32'h2000_0044);
        csr_wr(0, MTSEL, 32'h0);
        csr_wr(0, TDATA1, 32'h2000_0844);
        commit(1, 0, 4'b0001, 0, 0, 4'b0);
        chk("chain_half_nofire", {31'b0, trig_fire_valid}, 32'h0);
        rd_chk("chain_half_hit0", 0, TDATA1, 32'h2000_0844);
        commit(1, 0, 4'b0011, 0, 0, 4'b0);
        chk("chain_full_fire", {31'b0, trig_fire_valid}, 32'h1);
        rd_chk("chain_full_hit0", 0, TDATA1, 32'h2010_0844);
        csr_wr(0, MTSEL, 32'h1);
        rd_chk("chain_full_hit1", 0, TDATA1, 32'h2010_0044);

        // dmode/action gating on trigger 2.
        csr_wr(0, MTSEL, 32'h2);
        csr_wr(0, TDATA1, 32'h2800_1004);
        rd_chk("dmode_nodbg", 0, TDATA1, 32'h2000_0004);
        dec_dbg_mode = 2'b01;
        csr_wr(0, TDATA1, 32'h2800_1004);
        rd_chk("dmode_dbg", 0, TDATA1, 32'h2800_1004);
        dec_dbg_mode = 2'b00;
        csr_wr(0, TDATA1, 32'h2000_0000);
        rd_chk("dmode_locked", 0, TDATA1, 32'h2800_1004);
        commit(1, 0, 4'b0100, 0, 0, 4'b0);
        chk("halt_fire", {29'b0, trig_fire_valid, trig_fire_halt, trig_fire_slot}, 32'h6);
        dec_dbg_mode = 2'b01;
        csr_wr(0, TDATA1, 32'h2000_0004);
        dec_dbg_mode = 2'b00;

        // Dual commit, same thread: i0 wins, i1 hits not recorded.
        csr_wr(0, MTSEL, 32'h0);
        csr_wr(0, TDATA1, 32'h2000_0044);
        commit(1, 0, 4'b0001, 1, 0, 4'b0100);
        chk("dual_slot0", {29'b0, trig_fire_valid, trig_fire_halt, trig_fire_slot}, 32'h4);
        csr_wr(0, MTSEL, 32'h2);
        rd_chk("dual_trig2_nohit", 0, TDATA1, 32'h2000_0004);

        // Reset during a firing commit.
        rst_l = 0;
        commit(1, 0, 4'b0100, 0, 0, 4'b0);
        rst_l = 1;
        chk("rst_nofire", {31'b0, trig_fire_valid}, 32'h0);
        rd_chk("rst_mtsel", 0, MTSEL, 32'h0);
        rd_chk("rst_tdata1", 0, TDATA1, 32'h2000_0000);
        rd_chk("rst_tdata2", 0, TDATA2, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_l = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0) dec_dbg_mode = 2'($urandom);
            dec_csr_wen    = ($urandom_range(0, 9) < 4);
            dec_csr_wtid   = 1'($urandom);
            dec_csr_waddr  = addrs[$urandom_range(0, 4)];
            dec_csr_wrdata = $urandom;
            if ($urandom_range(0, 3) != 0) dec_csr_wrdata[27] = 1'b0;
            i0_commit_valid = 1'($urandom);
            i1_commit_valid = 1'($urandom);
            i0_commit_tid   = 1'($urandom);
            i1_commit_tid   = 1'($urandom);
            i0_trigger_raw  = 4'($urandom & $urandom);
            i1_trigger_raw  = 4'($urandom & $urandom);
            step();
            idle_inputs();
            pkt_chk();
            begin
                bit rt;
                logic [11:0] ra;
                rt = 1'($urandom);
                ra = addrs[$urandom_range(0, 4)];
                rd_chk("rand_read", rt, ra, m_read(rt, ra));
            end
        end

        rst_l = 1;
        step(); step(); step();
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
